// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run/step controller: command modes, stop causes and FSM states.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ModeRun        = 2'd0,
        ModeMicroStep  = 2'd1,
        ModeInstrStep  = 2'd2,
        ModeRunN       = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        CauseNone     = 3'd0,
        CauseHalt     = 3'd1,
        CauseError    = 3'd2,
        CauseStopReq  = 3'd3,
        CauseStepDone = 3'd4,
        CauseBudget   = 3'd5
    } cause_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2,
        StFault  = 2'd3
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with synchronous load, count enable and asynchronous clear.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_en,
    input  logic             i_down,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_limit;

    // Up-counting sticks at all-ones, down-counting sticks at zero.
    assign w_at_limit = i_down ? (r_count == '0) : (r_count == '1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en && !w_at_limit) begin
            r_count <= i_down ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/run_controller.sv
// Run/step controller: gates the CPU clock enable per host command and reports why it stopped.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned                 TICK_WIDTH   = 64,
    parameter int unsigned                 OPCODE_WIDTH = 7,
    parameter logic [OPCODE_WIDTH-1:0]     HALT_OPCODE  = {OPCODE_WIDTH{1'b1}},
    parameter int unsigned                 ERROR_WIDTH  = 2,
    parameter int unsigned                 BUDGET_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    notReset,
    input  logic                    cmdValid,
    output logic                    cmdReady,
    input  logic [1:0]              cmdMode,
    input  logic [BUDGET_WIDTH-1:0] cmdCount,
    input  logic                    stopReq,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [ERROR_WIDTH-1:0]  error,
    input  logic                    atFetch,
    output logic                    cpuEnable,
    output logic [TICK_WIDTH-1:0]   tickCount,
    output logic                    busy,
    output logic                    doneValid,
    output logic [2:0]              stopCause,
    output logic [ERROR_WIDTH-1:0]  errorCode
);

    state_e                  r_state;
    mode_e                   r_mode;
    cause_e                  r_cause;
    logic                    r_stepped;
    logic                    r_done;
    logic [ERROR_WIDTH-1:0]  r_err_code;

    logic [BUDGET_WIDTH-1:0] w_budget;
    logic                    w_in_run;
    logic                    w_accept;
    logic                    w_ticked;
    logic                    w_halt;
    logic                    w_fault;
    logic                    w_step_done;
    logic                    w_budget_done;
    logic                    w_enable;

    assign w_in_run      = (r_state == StRun);
    assign w_accept      = (r_state == StIdle) && cmdValid;
    // Opcode/error are garbage until the CPU has executed at least one cycle.
    assign w_ticked      = (tickCount != '0);
    assign w_halt        = w_in_run && w_ticked && (opcode == HALT_OPCODE);
    assign w_fault       = w_in_run && w_ticked && (error != '0);
    assign w_step_done   = w_in_run && (r_mode == ModeInstrStep) && r_stepped && atFetch;
    assign w_budget_done = w_in_run && (r_mode == ModeRunN) && (w_budget == '0);
    assign w_enable      = w_in_run && !w_halt && !w_fault && !stopReq
                           && !w_step_done && !w_budget_done;

    sat_counter #(
        .WIDTH(TICK_WIDTH)
    ) u_tick_counter (
        .i_clk        (clock),
        .i_rst_n      (notReset),
        .i_load       (1'b0),
        .i_load_value ('0),
        .i_en         (w_enable),
        .i_down       (1'b0),
        .o_count      (tickCount)
    );

    sat_counter #(
        .WIDTH(BUDGET_WIDTH)
    ) u_budget_counter (
        .i_clk        (clock),
        .i_rst_n      (notReset),
        .i_load       (w_accept),
        .i_load_value (cmdCount),
        .i_en         (w_enable && (r_mode == ModeRunN)),
        .i_down       (1'b1),
        .o_count      (w_budget)
    );

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            r_state    <= StIdle;
            r_mode     <= ModeRun;
            r_cause    <= CauseNone;
            r_stepped  <= 1'b0;
            r_done     <= 1'b0;
            r_err_code <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (cmdValid) begin
                        r_state   <= StRun;
                        r_mode    <= mode_e'(cmdMode);
                        r_cause   <= CauseNone;
                        r_stepped <= 1'b0;
                    end
                end
                StRun: begin
                    if (w_halt) begin
                        r_state <= StHalted;
                        r_cause <= CauseHalt;
                        r_done  <= 1'b1;
                    end else if (w_fault) begin
                        r_state    <= StFault;
                        r_cause    <= CauseError;
                        r_err_code <= error;
                        r_done     <= 1'b1;
                    end else if (stopReq) begin
                        r_state <= StIdle;
                        r_cause <= CauseStopReq;
                        r_done  <= 1'b1;
                    end else if (w_step_done) begin
                        r_state <= StIdle;
                        r_cause <= CauseStepDone;
                        r_done  <= 1'b1;
                    end else if (w_budget_done) begin
                        r_state <= StIdle;
                        r_cause <= CauseBudget;
                        r_done  <= 1'b1;
                    end else begin
                        r_stepped <= 1'b1;
                        if (r_mode == ModeMicroStep) begin
                            r_state <= StIdle;
                            r_cause <= CauseStepDone;
                            r_done  <= 1'b1;
                        end
                    end
                end
                // Halted and fault are left only through reset.
                default: ;
            endcase
        end
    end

    assign cmdReady  = (r_state == StIdle);
    assign busy      = w_in_run;
    assign cpuEnable = w_enable;
    assign doneValid = r_done;
    assign stopCause = r_cause;
    assign errorCode = r_err_code;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: command table, randomized commands against an arithmetic model,
// and hand sequences for halt masking, fault stickiness, priority, reset and saturation.
module tb_run_controller;

    localparam logic [1:0] M_RUN   = 2'd0;
    localparam logic [1:0] M_MICRO = 2'd1;
    localparam logic [1:0] M_INSTR = 2'd2;
    localparam logic [1:0] M_RUNN  = 2'd3;

    localparam logic [2:0] C_NONE   = 3'd0;
    localparam logic [2:0] C_HALT   = 3'd1;
    localparam logic [2:0] C_ERROR  = 3'd2;
    localparam logic [2:0] C_STOP   = 3'd3;
    localparam logic [2:0] C_STEP   = 3'd4;
    localparam logic [2:0] C_BUDGET = 3'd5;

    localparam logic [6:0] HALT = 7'h7f;

    logic        clock = 1'b0;
    logic        notReset = 1'b0;
    logic        cmdValid = 1'b0;
    logic [1:0]  cmdMode = 2'd0;
    logic [31:0] cmdCount = 32'd0;
    logic        stopReq = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [1:0]  error = 2'd0;
    logic        atFetch = 1'b0;

    logic        cmdReady, cpuEnable, busy, doneValid;
    logic [63:0] tickCount;
    logic [2:0]  stopCause;
    logic [1:0]  errorCode;

    logic        cmdReady2, cpuEnable2, busy2, doneValid2;
    logic [3:0]  tickCount2;
    logic [2:0]  stopCause2;
    logic [1:0]  errorCode2;

    int total = 0;
    int bad = 0;

    run_controller dut (
        .clock     (clock),
        .notReset  (notReset),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdMode   (cmdMode),
        .cmdCount  (cmdCount),
        .stopReq   (stopReq),
        .opcode    (opcode),
        .error     (error),
        .atFetch   (atFetch),
        .cpuEnable (cpuEnable),
        .tickCount (tickCount),
        .busy      (busy),
        .doneValid (doneValid),
        .stopCause (stopCause),
        .errorCode (errorCode)
    );

    run_controller #(
        .TICK_WIDTH(4)
    ) dut_narrow (
        .clock     (clock),
        .notReset  (notReset),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady2),
        .cmdMode   (cmdMode),
        .cmdCount  (cmdCount),
        .stopReq   (stopReq),
        .opcode    (opcode),
        .error     (error),
        .atFetch   (atFetch),
        .cpuEnable (cpuEnable2),
        .tickCount (tickCount2),
        .busy      (busy2),
        .doneValid (doneValid2),
        .stopCause (stopCause2),
        .errorCode (errorCode2)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Enters and leaves at one time unit after a rising edge.
    task automatic do_reset();
        cmdValid = 1'b0;
        stopReq  = 1'b0;
        opcode   = '0;
        error    = '0;
        atFetch  = 1'b0;
        notReset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        notReset = 1'b1;
    endtask

    // Offer one command, then drive RUN-cycle j (1 = first cycle after acceptance) with
    // stopReq from stop_at on, atFetch at cycle 1 and fetch_at, error from err_at on.
    task automatic run_cmd(input logic [1:0] mode, input logic [31:0] count, input int stop_at,
                           input int fetch_at, input int err_at, input logic [1:0] err_val,
                           input int max_cyc, output int n_en, output logic [2:0] cause,
                           output int done_cyc);
        n_en     = 0;
        cause    = C_NONE;
        done_cyc = 0;
        cmdValid = 1'b1;
        cmdMode  = mode;
        cmdCount = count;
        stopReq  = (stop_at == 1);
        error    = '0;
        atFetch  = 1'b0;
        #3;
        check("accept_ready", cmdReady, 1);
        check("accept_no_enable", cpuEnable, 0);
        @(posedge clock);
        #1;
        cmdValid = 1'b0;
        for (int j = 1; j <= max_cyc; j++) begin
            stopReq = (stop_at != 0) && (j >= stop_at);
            atFetch = (j == 1) || (j == fetch_at);
            error   = (err_at != 0 && j >= err_at) ? err_val : 2'd0;
            #3;
            if (cpuEnable) n_en++;
            if (doneValid) begin
                done_cyc = j;
                cause    = stopCause;
            end
            @(posedge clock);
            #1;
            if (done_cyc != 0) break;
        end
        stopReq = 1'b0;
        atFetch = 1'b0;
        error   = '0;
        if (done_cyc != 0) check("done_pulse_width", doneValid, 0);
    endtask

    // Outcome of one command from the stopping rules, in RUN-cycle arithmetic.
    function automatic void model(input logic [1:0] mode, input int count, input int s,
                                  input int f, output int en, output logic [2:0] cause,
                                  output int done);
        int          t_nat;
        logic [2:0]  c_nat;
        if (mode == M_MICRO) begin
            en    = (s == 1) ? 0 : 1;
            cause = (s == 1) ? C_STOP : C_STEP;
            done  = 2;
            return;
        end
        case (mode)
            M_RUNN:  begin t_nat = count + 1; c_nat = C_BUDGET; end
            M_INSTR: begin t_nat = f;         c_nat = C_STEP;   end
            default: begin t_nat = 1000000;   c_nat = C_NONE;   end
        endcase
        if (s != 0 && s <= t_nat) begin
            en    = s - 1;
            cause = C_STOP;
            done  = s + 1;
        end else begin
            en    = t_nat - 1;
            cause = c_nat;
            done  = t_nat + 1;
        end
    endfunction

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] count;
        int          stop_at;
        int          fetch_at;
        int          exp_en;
        logic [2:0]  exp_cause;
        int          exp_done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          en, dn, m_en, m_dn, leaks;
        logic [2:0]  cs, m_cs;
        logic [63:0] tick_exp;
        logic [1:0]  r_mode;
        int          r_cnt, r_stop, r_fetch;

        vecs[0] = '{M_RUNN,  32'd5, 0, 0, 5, C_BUDGET, 7};
        vecs[1] = '{M_RUNN,  32'd0, 0, 0, 0, C_BUDGET, 2};
        vecs[2] = '{M_RUN,   32'd0, 4, 0, 3, C_STOP,   5};
        vecs[3] = '{M_MICRO, 32'd0, 0, 0, 1, C_STEP,   2};
        vecs[4] = '{M_INSTR, 32'd0, 0, 5, 4, C_STEP,   6};
        vecs[5] = '{M_RUNN,  32'd3, 4, 0, 3, C_STOP,   5};
        vecs[6] = '{M_MICRO, 32'd0, 1, 0, 0, C_STOP,   2};
        vecs[7] = '{M_INSTR, 32'd0, 3, 9, 2, C_STOP,   4};

        do_reset();
        check("reset_tick", tickCount, 0);
        check("reset_ready", cmdReady, 1);
        check("reset_busy", busy, 0);
        check("reset_done", doneValid, 0);
        check("reset_cause", stopCause, C_NONE);
        check("reset_errcode", errorCode, 0);
        check("reset_enable", cpuEnable, 0);

        // Halt opcode present from the start is masked for the very first cycle.
        opcode = HALT;
        run_cmd(M_RUN, 32'd0, 0, 0, 0, 2'd0, 20, en, cs, dn);
        check("halt_en", en, 1);
        check("halt_cause", cs, C_HALT);
        check("halt_done", dn, 3);
        check("halt_ready", cmdReady, 0);
        check("halt_busy", busy, 0);
        check("halt_tick", tickCount, 1);

        // Error and stop in the same cycle: error has priority.
        do_reset();
        run_cmd(M_RUN, 32'd0, 4, 0, 4, 2'b01, 40, en, cs, dn);
        check("prio_en", en, 3);
        check("prio_cause", cs, C_ERROR);
        check("prio_done", dn, 5);
        check("prio_errcode", errorCode, 1);

        do_reset();
        tick_exp = 0;
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].mode, vecs[i].count, vecs[i].stop_at, vecs[i].fetch_at, 0, 2'd0,
                    40, en, cs, dn);
            tick_exp += 64'(vecs[i].exp_en);
            check("vec_en", en, vecs[i].exp_en);
            check("vec_cause", cs, vecs[i].exp_cause);
            check("vec_done", dn, vecs[i].exp_done);
            check("vec_tick", tickCount, tick_exp);
        end

        for (int i = 0; i < 30; i++) begin
            r_mode  = 2'($urandom_range(3, 0));
            r_cnt   = int'($urandom_range(8, 0));
            r_fetch = int'($urandom_range(10, 2));
            r_stop  = ($urandom_range(2, 0) == 0) ? 0 : int'($urandom_range(12, 1));
            if (r_mode == M_RUN && r_stop == 0) r_stop = int'($urandom_range(12, 1));
            model(r_mode, r_cnt, r_stop, r_fetch, m_en, m_cs, m_dn);
            run_cmd(r_mode, 32'(r_cnt), r_stop, r_fetch, 0, 2'd0, 40, en, cs, dn);
            tick_exp += 64'(m_en);
            check("rnd_en", en, m_en);
            check("rnd_cause", cs, m_cs);
            check("rnd_done", dn, m_dn);
            check("rnd_tick", tickCount, tick_exp);
        end

        // Saturation on the 4-bit copy, then reset while running.
        do_reset();
        run_cmd(M_RUN, 32'd0, 0, 0, 0, 2'd0, 20, en, cs, dn);
        check("sat_en", en, 20);
        check("sat_no_done", dn, 0);
        check("sat_tick_wide", tickCount, 20);
        check("sat_tick_narrow", tickCount2, 15);
        check("sat_narrow_enable", cpuEnable2, 1);
        check("sat_narrow_busy", busy2, 1);
        check("sat_narrow_ready", cmdReady2, 0);
        check("sat_narrow_done", doneValid2, 0);
        check("sat_narrow_cause", stopCause2, C_NONE);
        check("sat_narrow_errcode", errorCode2, 0);
        check("midrun_enable_before", cpuEnable, 1);
        notReset = 1'b0;
        #1;
        check("midrun_enable_drop", cpuEnable, 0);
        check("midrun_tick", tickCount, 0);
        check("midrun_busy", busy, 0);
        @(posedge clock);
        #1;
        notReset = 1'b1;
        leaks = 0;
        repeat (4) begin
            #3;
            if (doneValid) leaks++;
            @(posedge clock);
            #1;
        end
        check("midrun_no_done", leaks, 0);

        // Fault after 10 enabled cycles is sticky until reset.
        do_reset();
        run_cmd(M_RUN, 32'd0, 0, 0, 11, 2'b10, 40, en, cs, dn);
        check("fault_en", en, 10);
        check("fault_cause", cs, C_ERROR);
        check("fault_done", dn, 12);
        check("fault_errcode", errorCode, 2);
        check("fault_ready", cmdReady, 0);
        opcode   = HALT;
        stopReq  = 1'b1;
        cmdValid = 1'b1;
        cmdMode  = M_RUN;
        leaks    = 0;
        repeat (5) begin
            #3;
            if (cmdReady || cpuEnable || doneValid || busy) leaks++;
            @(posedge clock);
            #1;
        end
        check("fault_sticky", leaks, 0);
        check("fault_cause_hold", stopCause, C_ERROR);
        check("fault_errcode_hold", errorCode, 2);
        cmdValid = 1'b0;
        stopReq  = 1'b0;
        opcode   = '0;
        #2;
        notReset = 1'b0;
        #1;
        check("fault_reset_tick", tickCount, 0);
        check("fault_reset_ready", cmdReady, 1);
        check("fault_reset_cause", stopCause, C_NONE);
        @(posedge clock);
        #1;
        notReset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_controller.md
# run_controller

Synthesizable run/step controller that gates the CPU clock enable, replacing the free-running clock loop and halt/error polling the bench does today. It accepts run commands (free run, single micro-step, single instruction step, run N cycles), counts enabled cycles, and stops on halt opcode, CPU error, external stop request or command completion. It reports a stop cause. It sits between the debug/host interface and the `cpu` clock-enable input, and snoops `irOpcode`, `error` and the microsequencer fetch address.

## Interface
Parameters:
- `TICK_WIDTH`, 64: width of the enabled-cycle counter.
- `OPCODE_WIDTH`, 7: width of the opcode input.
- `HALT_OPCODE`, 7'b1111111: opcode value that means halt.
- `ERROR_WIDTH`, 2: width of the CPU error input.
- `BUDGET_WIDTH`, 32: width of the RUN_N cycle count.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `notReset`  in  1  asynchronous, active-low reset.
- `cmdValid`  in  1  command offered.
- `cmdReady`  out  1  controller can accept a command.
- `cmdMode`  in  2  0 RUN, 1 MICRO_STEP, 2 INSTR_STEP, 3 RUN_N.
- `cmdCount`  in  BUDGET_WIDTH  cycle budget; used only for RUN_N.
- `stopReq`  in  1  level request to stop a running command.
- `opcode`  in  OPCODE_WIDTH  current CPU instruction-register opcode.
- `error`  in  ERROR_WIDTH  CPU error code; nonzero means fault.
- `atFetch`  in  1  microsequencer is at the fetch entry point.
- `cpuEnable`  out  1  CPU clock enable for this cycle.
- `tickCount`  out  TICK_WIDTH  enabled cycles since reset.
- `busy`  out  1  state is RUN.
- `doneValid`  out  1  one-cycle pulse: command finished.
- `stopCause`  out  3  0 NONE, 1 HALT, 2 ERROR, 3 STOPREQ, 4 STEP_DONE, 5 BUDGET.
- `errorCode`  out  ERROR_WIDTH  `error` value captured at fault.

## Operation
- States: IDLE, RUN, HALTED, FAULT.
- Reset (asynchronous, while `notReset`=0): state IDLE, `tickCount`=0, `cpuEnable`=0, `busy`=0, `doneValid`=0, `stopCause`=NONE, `errorCode`=0, budget and step flags cleared.
- IDLE:
  - `cmdReady`=1; `cpuEnable`=0.
  - `cmdValid`&&`cmdReady` at an edge latches mode, loads budget from `cmdCount`, clears the stepped flag, and moves to RUN.
- RUN: evaluated each cycle, priority highest first.
  1. `tickCount`!=0 && `opcode`==HALT_OPCODE: HALTED, cause HALT.
  2. `tickCount`!=0 && `error`!=0: FAULT, cause ERROR, `errorCode`←`error`.
  3. `stopReq`: IDLE, cause STOPREQ.
  4. Mode-dependent completion:
     - INSTR_STEP with stepped flag set and `atFetch`=1: IDLE, cause STEP_DONE.
     - RUN_N with budget==0: IDLE, cause BUDGET.
  5. Otherwise `cpuEnable`=1, `tickCount`+1 (saturates at all-ones), stepped flag set, RUN_N budget −1.
     - MICRO_STEP: this enabled cycle is the only one; go IDLE, cause STEP_DONE.
     - RUN: continues until one of cases 1–3 fires.
- In cases 1–4 `cpuEnable`=0 for that cycle.
- The halt/error guard `tickCount`!=0 masks power-up garbage in `opcode`/`error`.
- HALTED and FAULT are sticky: `cmdReady`=0, `cpuEnable`=0, exit only by reset.
- `stopCause` and `errorCode` hold until the next accepted command, which clears `stopCause` to NONE.

## Timing
- `cpuEnable` is combinational from the registered state and the current inputs. There are no enabled cycles in the acceptance cycle; the first possible enabled cycle is the cycle after acceptance.
- `doneValid` is registered: high for exactly one cycle, the first cycle in the destination state, with `stopCause` valid in that same cycle.
- MICRO_STEP: accept at edge 0; enabled during cycle 1; `doneValid` in cycle 2.
- RUN_N with `cmdCount`=0: zero enabled cycles; `doneValid`/BUDGET one cycle after RUN entry.
- `stopReq` asserted in the acceptance cycle is ignored; it is sampled only in RUN.
- A command offered while `busy` is not accepted; `cmdValid` is held by the requester.
- Reset mid-RUN: `cpuEnable` drops immediately (asynchronous); `tickCount` returns to 0; no `doneValid` is generated.

## Structure
- Package `run_ctrl_pkg`: mode encodings, stopCause encodings, state encodings.
- Sub-module `sat_counter` (parametrised width, enable, asynchronous clear): used for `tickCount`, and as a down-counter for the budget with a decrement option.
- Halt/error detection and the next-state logic remain in `run_controller`.

## Test plan
- Reset, then RUN with `opcode`=HALT_OPCODE from the start: halt is masked while `tickCount`=0. Exactly 1 enabled cycle occurs, then `stopCause`=HALT, state HALTED, `cmdReady`=0.
- RUN_N `cmdCount`=5, no events: exactly 5 `cpuEnable` cycles, `tickCount`=5, `doneValid` with BUDGET one cycle after the last enable. Then RUN_N `cmdCount`=0: 0 enables, BUDGET.
- INSTR_STEP with `atFetch` high at command start and again 4 enabled cycles later: exactly 4 enables, then STEP_DONE.
- RUN, `error`=2'b10 after 10 enabled cycles: `cpuEnable`=0 that cycle, FAULT, `errorCode`=2, halt/stop/commands ignored afterwards. Then reset mid-fault: state IDLE, `tickCount`=0.
- RUN with `stopReq` and `error` both asserted after cycle 3: ERROR wins (priority). Repeat with only `stopReq`: STOPREQ, IDLE, a new MICRO_STEP is accepted and gives exactly 1 enable.
- Saturation with TICK_WIDTH=4: RUN 20 cycles, `tickCount` holds at 15.
